mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the fetch stage (instruction
//  port) and the memory stage (data port) of the 5-stage pipeline.
//  Grants one access at a time and sequences the fixed-latency memory.
//  Returns read data with a one-cycle ack pulse to each requester.
//  Drives stall requests that feed the pipeline's HoldPC/Hold_data/Stall_EN logic.
// PARAMETERS
//  ADDR_W   32  byte address width of both ports and memory
//  DATA_W   32  data width
//  MEM_LAT  2   memory read latency in cycles; data is valid MEM_LAT edges after mem_en is sampled; legal range 1..15
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-low reset
//  if_req     in   1       instruction fetch request, held until if_ack
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  DATA_W  fetched instruction, valid while if_ack=1
//  if_ack     out  1       one-cycle completion pulse for fetch
//  d_req      in   1       data access request, held until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address (ALU result)
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid while d_ack=1
//  d_ack      out  1       one-cycle completion pulse for data
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  stall_if   out  1       if_req & ~if_ack (combinational)
//  stall_mem  out  1       d_req & ~d_ack (combinational)
// BEHAVIOUR
//  - Reset (rst=0 at an edge): state IDLE; latency counter 0.
//    All registered outputs (acks, rdata, mem_*) are 0.
//    Reset aborts any access in flight; its returning memory data is discarded.
//  - FSM states: IDLE, BUSY_I, BUSY_D.
//  - IDLE: each requester's eligibility is evaluated.
//    A requester is eligible if its req=1 and its ack is not high in this cycle.
//    The acked-requester mask prevents a spurious re-grant while that requester drops req.
//    If D is eligible, go to BUSY_D. Else if I is eligible, go to BUSY_I. Else stay in IDLE.
//    D has fixed priority over I.
//  - Grant edge: the granted address, we and wdata are latched into the mem_* registers.
//    For I grants, mem_we=0. mem_en=1 for exactly the next cycle.
//    The counter is loaded with MEM_LAT.
//  - BUSY_x: the counter decrements each edge.
//    At the edge where the counter is 1, mem_rdata is captured into x_rdata (loads and fetches only).
//    At that edge x_ack is set to 1 for one cycle and the FSM returns to IDLE.
//  - Latency: request sampled at edge E0 gives ack high in cycle MEM_LAT+2 after E0.
//    Stores use the same timing. d_rdata is unchanged on store acks.
//  - Throughput: a new grant may be made in the ack cycle, for the other requester only.
//    Both ports requesting continuously therefore alternate D, I, D, I.
//  - Req dropped mid-access: the access completes and ack still pulses once.
//    Requesters ignore such an ack.
//  - Port inputs are sampled only at the grant edge. Later changes to addr/wdata do not affect the access in flight.
//  - if_rdata/d_rdata hold their last value between acks. mem_addr/mem_wdata hold after mem_en drops.
//  - Counter width is 4 bits. MEM_LAT=0 is illegal and must trip an elaboration check.
// STRUCTURE
//  - Shared package mips_pkg: FSM state encoding (IDLE/BUSY_I/BUSY_D) and the ADDR_W/DATA_W defaults.
//  - One sub-module: mem_lat_counter, a loadable down-counter with a last-cycle flag, parameterised by MEM_LAT.
//  - All other logic is inline. stall_* is the only combinational output logic.
// TESTING (MEM_LAT=2, behavioural sync memory model)
//  1. Reset 3 cycles with both req=1 -> mem_en=0, acks=0, rdata=0. Release -> first grant goes to D.
//  2. Fetch only, if_addr=0x0000_0040, mem[0x40]=0x2008_0005 -> mem_en in cycle 1, if_ack in cycle 4
//     with if_rdata=0x2008_0005; stall_if=1 in cycles 0-3.
//  3. Both req held: d load 0x100 (mem=0xDEAD_BEEF), if fetch 0x44 -> d_ack at cycle 4, then I granted in the same cycle,
//     if_ack at cycle 8.
//  4. Store d_we=1 addr 0x200 wdata 0x1234_5678 -> mem_we=1 with mem_en. d_ack at cycle 4 with d_rdata unchanged.
//     A subsequent load of 0x200 returns 0x1234_5678.
//  5. rst=0 at the edge of cycle 2 of a fetch -> no if_ack. Memory return ignored. IDLE next cycle.
//  6. d_req dropped one cycle after grant -> d_ack still pulses at cycle 4. No extra mem_en issued.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline memory arbiter.
// State encoding, default widths and the latency counter width.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that tracks the fixed memory read latency.
// last_o flags the cycle in which the counter holds 1.
module mem_lat_counter
    import mips_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
        $error("mem_lat_counter: MEM_LAT must be in 1..15");
    end

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LAT_CNT_W'(MEM_LAT);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and memory stages.
// Data port has fixed priority; an acked port is masked for its ack cycle.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q, state_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_last;
    logic i_elig;
    logic d_elig;
    logic done;

    assign d_elig = d_req & ~d_ack_q;
    assign i_elig = if_req & ~if_ack_q;

    // Latency is counted from the edge where the memory samples mem_en.
    assign cnt_dec = (state_q != IDLE) & ~mem_en_q;
    assign done    = cnt_dec & cnt_last;

    mem_lat_counter #(
        .MEM_LAT(MEM_LAT)
    ) u_lat (
        .clk_i (clk),
        .rst_ni(rst),
        .load_i(cnt_load),
        .dec_i (cnt_dec),
        .last_o(cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        cnt_load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_elig) begin
                    state_d     = BUSY_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_load    = 1'b1;
                end else if (i_elig) begin
                    state_d    = BUSY_I;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_load   = 1'b1;
                end
            end
            BUSY_I: begin
                if (done) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                    d_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = d_req & ~d_ack_q;

endmodule
